// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: decoded record, prefix
// attributes, opcode attribute record and prefix byte constants.
package instruction_fetch_unit_pkg;

    localparam int unsigned PC_W  = 16;
    localparam int unsigned LEN_W = 4;

    typedef enum logic [1:0] {
        SREG_DS1 = 2'd0,
        SREG_PS  = 2'd1,
        SREG_SS  = 2'd2,
        SREG_DS0 = 2'd3
    } sreg_index_e;

    typedef enum logic [2:0] {
        REP_NONE  = 3'd0,
        REP_REP   = 3'd1,
        REP_REPNE = 3'd2,
        REP_REPC  = 3'd3,
        REP_REPNC = 3'd4
    } rep_e;

    typedef struct packed {
        logic [PC_W-1:0]  start_pc;
        logic [LEN_W-1:0] len;
        logic             seg_valid;
        sreg_index_e      seg;
        rep_e             rep;
        logic             buslock;
        logic             ext;
        logic [7:0]       opcode;
        logic [7:0]       modrm;
        logic [15:0]      disp16;
        logic [15:0]      imm16;
        logic [7:0]       imm8b;
    } decoded_instr_t;

    typedef struct packed {
        logic       is_prefix;
        logic       has_modrm;
        logic       imm_if_reg0;
        logic [1:0] imm_size;
    } opcode_attr_t;

    localparam logic [7:0] PFX_DS1   = 8'h26;
    localparam logic [7:0] PFX_PS    = 8'h2E;
    localparam logic [7:0] PFX_SS    = 8'h36;
    localparam logic [7:0] PFX_DS0   = 8'h3E;
    localparam logic [7:0] PFX_LOCK  = 8'hF0;
    localparam logic [7:0] PFX_REPNE = 8'hF2;
    localparam logic [7:0] PFX_REP   = 8'hF3;
    localparam logic [7:0] PFX_REPNC = 8'h64;
    localparam logic [7:0] PFX_REPC  = 8'h65;
    localparam logic [7:0] OP_EXT    = 8'h0F;

    function automatic opcode_attr_t attr_mk(logic modrm, logic [1:0] imm, logic reg0);
        opcode_attr_t a;
        a.is_prefix   = 1'b0;
        a.has_modrm   = modrm;
        a.imm_size    = imm;
        a.imm_if_reg0 = reg0;
        return a;
    endfunction

    // Displacement bytes implied by a ModR/M byte.
    function automatic logic [1:0] modrm_disp_size(logic [7:0] m);
        logic [1:0] ds;
        ds = 2'd0;
        if (m[7:6] == 2'b00 && m[2:0] == 3'b110) ds = 2'd2;
        else if (m[7:6] == 2'b01)                ds = 2'd1;
        else if (m[7:6] == 2'b10)                ds = 2'd2;
        return ds;
    endfunction

endpackage

// File: rtl/opcode_attr_rom.sv
// Combinational opcode attribute table.
//   ext  : 1 selects the 0x0F extended table
//   op   : opcode byte
//   attr : prefix flag, ModR/M presence, immediate size, F6/F7 reg-0 immediate rule
module opcode_attr_rom
    import instruction_fetch_unit_pkg::*;
(
    input  logic         ext,
    input  logic [7:0]   op,
    output opcode_attr_t attr
);

    always_comb begin
        attr = '0;
        if (!ext) begin
            // 00-3F ALU rows: columns 0-3 are r/m forms, 4 is acc,imm8, 5 is acc,imm16
            if (op[7:6] == 2'b00) begin
                if (op[2] == 1'b0)          attr = attr_mk(1'b1, 2'd0, 1'b0);
                else if (op[2:0] == 3'd4)   attr = attr_mk(1'b0, 2'd1, 1'b0);
                else if (op[2:0] == 3'd5)   attr = attr_mk(1'b0, 2'd2, 1'b0);
            end
            case (op) inside
                PFX_DS1, PFX_PS, PFX_SS, PFX_DS0, PFX_LOCK,
                PFX_REPNE, PFX_REP, PFX_REPNC, PFX_REPC: attr.is_prefix = 1'b1;
                8'h62:                          attr = attr_mk(1'b1, 2'd0, 1'b0);
                8'h68:                          attr = attr_mk(1'b0, 2'd2, 1'b0);
                8'h69:                          attr = attr_mk(1'b1, 2'd2, 1'b0);
                8'h6A:                          attr = attr_mk(1'b0, 2'd1, 1'b0);
                8'h6B:                          attr = attr_mk(1'b1, 2'd1, 1'b0);
                [8'h70:8'h7F]:                  attr = attr_mk(1'b0, 2'd1, 1'b0);
                8'h80, 8'h82, 8'h83:            attr = attr_mk(1'b1, 2'd1, 1'b0);
                8'h81:                          attr = attr_mk(1'b1, 2'd2, 1'b0);
                [8'h84:8'h8F]:                  attr = attr_mk(1'b1, 2'd0, 1'b0);
                // Far pointer forms: only the offset word fits the record.
                8'h9A, 8'hEA:                   attr = attr_mk(1'b0, 2'd2, 1'b0);
                [8'hA0:8'hA3]:                  attr = attr_mk(1'b0, 2'd2, 1'b0);
                8'hA8:                          attr = attr_mk(1'b0, 2'd1, 1'b0);
                8'hA9:                          attr = attr_mk(1'b0, 2'd2, 1'b0);
                [8'hB0:8'hB7]:                  attr = attr_mk(1'b0, 2'd1, 1'b0);
                [8'hB8:8'hBF]:                  attr = attr_mk(1'b0, 2'd2, 1'b0);
                8'hC0, 8'hC1, 8'hC6:            attr = attr_mk(1'b1, 2'd1, 1'b0);
                8'hC2, 8'hCA:                   attr = attr_mk(1'b0, 2'd2, 1'b0);
                8'hC4, 8'hC5:                   attr = attr_mk(1'b1, 2'd0, 1'b0);
                8'hC7:                          attr = attr_mk(1'b1, 2'd2, 1'b0);
                8'hC8:                          attr = attr_mk(1'b0, 2'd3, 1'b0);
                8'hCD, 8'hD4, 8'hD5, 8'hEB:     attr = attr_mk(1'b0, 2'd1, 1'b0);
                [8'hD0:8'hD3], [8'hD8:8'hDF]:   attr = attr_mk(1'b1, 2'd0, 1'b0);
                [8'hE0:8'hE7]:                  attr = attr_mk(1'b0, 2'd1, 1'b0);
                8'hE8, 8'hE9:                   attr = attr_mk(1'b0, 2'd2, 1'b0);
                8'hF6:                          attr = attr_mk(1'b1, 2'd1, 1'b1);
                8'hF7:                          attr = attr_mk(1'b1, 2'd2, 1'b1);
                8'hFE, 8'hFF:                   attr = attr_mk(1'b1, 2'd0, 1'b0);
                default: ;
            endcase
        end else begin
            case (op) inside
                [8'h10:8'h17]:                  attr = attr_mk(1'b1, 2'd0, 1'b0);
                [8'h18:8'h1F]:                  attr = attr_mk(1'b1, 2'd1, 1'b0);
                8'h28, 8'h2A, 8'h31, 8'h33:     attr = attr_mk(1'b1, 2'd0, 1'b0);
                8'h39, 8'h3B:                   attr = attr_mk(1'b1, 2'd1, 1'b0);
                8'hFF:                          attr = attr_mk(1'b0, 2'd1, 1'b0);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: pulls bytes from the 8-byte prefetch queue one per
// ce_1, assembles a decoded V33 instruction record and hands it to the EU.
//   ipq/ipq_len        : prefetch queue window and byte count from the BCU
//   ipq_head/pfp_set   : consume pointer and prefetch pointer reload strobe
//   redirect/_pc       : flush request and new PS offset from the EU
//   instr_valid/ack    : record handshake; instr is the decoded record
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned MAX_LEN = 15
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ce_1,
    input  logic            ce_2,
    input  logic [7:0][7:0] ipq,
    input  logic [3:0]      ipq_len,
    output logic [15:0]     ipq_head,
    output logic            pfp_set,
    input  logic            redirect,
    input  logic [15:0]     redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ack,
    output decoded_instr_t  instr
);

    typedef enum logic [2:0] {
        ST_OPCODE, ST_OPCODE2, ST_MODRM, ST_DISP, ST_IMM, ST_HOLD
    } state_e;

    state_e         state_q, state_d, st_w;
    logic [15:0]    ipq_head_q, ipq_head_d;
    logic           pfp_set_q, pfp_set_d;
    logic           instr_valid_q, instr_valid_d;
    decoded_instr_t instr_q, instr_d, rec_w;
    logic [1:0]     disp_size_q, disp_size_d;
    logic [1:0]     imm_size_q, imm_size_d;
    logic           imm_if_reg0_q, imm_if_reg0_d;
    logic [1:0]     byte_idx_q, byte_idx_d;
    logic [1:0]     imm_eff_w, ds_w;
    logic [7:0]     byte_c;
    opcode_attr_t   attr_c;
    logic           unused_ce_2;

    assign unused_ce_2 = ce_2;
    assign byte_c      = ipq[ipq_head_q[2:0]];

    opcode_attr_rom u_rom (
        .ext  (state_q == ST_OPCODE2),
        .op   (byte_c),
        .attr (attr_c)
    );

    // Next-state: redirect first, then ack, then at most one byte consumed.
    always_comb begin
        state_d       = state_q;
        ipq_head_d    = ipq_head_q;
        pfp_set_d     = pfp_set_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        disp_size_d   = disp_size_q;
        imm_size_d    = imm_size_q;
        imm_if_reg0_d = imm_if_reg0_q;
        byte_idx_d    = byte_idx_q;
        st_w          = state_q;
        rec_w         = instr_q;
        imm_eff_w     = imm_size_q;
        ds_w          = 2'd0;

        if (ce_1) begin
            pfp_set_d = 1'b0;
            if (redirect) begin
                ipq_head_d    = redirect_pc;
                pfp_set_d     = 1'b1;
                instr_valid_d = 1'b0;
                instr_d       = '0;
                state_d       = ST_OPCODE;
            end else if (!pfp_set_q) begin
                // The cycle after a redirect is blanked: ipq_len is stale then.
                if (state_q == ST_HOLD && instr_ack) begin
                    st_w          = ST_OPCODE;
                    rec_w         = '0;
                    instr_valid_d = 1'b0;
                    instr_d       = '0;
                    state_d       = ST_OPCODE;
                end
                if (st_w != ST_HOLD && ipq_len != 4'd0) begin
                    ipq_head_d = ipq_head_q + 16'd1;
                    if (rec_w.len == '0)
                        rec_w.start_pc = ipq_head_q;
                    if (rec_w.len < LEN_W'(MAX_LEN))
                        rec_w.len = rec_w.len + LEN_W'(1);
                    case (st_w)
                        ST_OPCODE: begin
                            if (attr_c.is_prefix) begin
                                case (byte_c)
                                    PFX_DS1:   begin rec_w.seg_valid = 1'b1; rec_w.seg = SREG_DS1; end
                                    PFX_PS:    begin rec_w.seg_valid = 1'b1; rec_w.seg = SREG_PS;  end
                                    PFX_SS:    begin rec_w.seg_valid = 1'b1; rec_w.seg = SREG_SS;  end
                                    PFX_DS0:   begin rec_w.seg_valid = 1'b1; rec_w.seg = SREG_DS0; end
                                    PFX_LOCK:  rec_w.buslock = 1'b1;
                                    PFX_REPNE: rec_w.rep = REP_REPNE;
                                    PFX_REP:   rec_w.rep = REP_REP;
                                    PFX_REPNC: rec_w.rep = REP_REPNC;
                                    PFX_REPC:  rec_w.rep = REP_REPC;
                                    default: ;
                                endcase
                            end else if (byte_c == OP_EXT) begin
                                rec_w.ext = 1'b1;
                                st_w      = ST_OPCODE2;
                            end else begin
                                rec_w.opcode  = byte_c;
                                imm_size_d    = attr_c.imm_size;
                                imm_if_reg0_d = attr_c.imm_if_reg0;
                                byte_idx_d    = 2'd0;
                                st_w = attr_c.has_modrm ? ST_MODRM :
                                       (attr_c.imm_size != 2'd0) ? ST_IMM : ST_HOLD;
                            end
                        end
                        ST_OPCODE2: begin
                            rec_w.opcode  = byte_c;
                            imm_size_d    = attr_c.imm_size;
                            imm_if_reg0_d = attr_c.imm_if_reg0;
                            byte_idx_d    = 2'd0;
                            st_w = attr_c.has_modrm ? ST_MODRM :
                                   (attr_c.imm_size != 2'd0) ? ST_IMM : ST_HOLD;
                        end
                        ST_MODRM: begin
                            rec_w.modrm = byte_c;
                            // F6/F7 carry an immediate only for the TEST (reg 000) form
                            if (imm_if_reg0_q && byte_c[5:3] != 3'b000)
                                imm_eff_w = 2'd0;
                            ds_w        = modrm_disp_size(byte_c);
                            imm_size_d  = imm_eff_w;
                            disp_size_d = ds_w;
                            byte_idx_d  = 2'd0;
                            st_w = (ds_w != 2'd0) ? ST_DISP :
                                   (imm_eff_w != 2'd0) ? ST_IMM : ST_HOLD;
                        end
                        ST_DISP: begin
                            if (byte_idx_q == 2'd0) begin
                                rec_w.disp16 = (disp_size_q == 2'd1) ? {{8{byte_c[7]}}, byte_c}
                                                                     : {8'h00, byte_c};
                                byte_idx_d = 2'd1;
                            end else begin
                                rec_w.disp16[15:8] = byte_c;
                            end
                            if (byte_idx_q == 2'd1 || disp_size_q == 2'd1) begin
                                byte_idx_d = 2'd0;
                                st_w = (imm_size_q != 2'd0) ? ST_IMM : ST_HOLD;
                            end
                        end
                        ST_IMM: begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            case (byte_idx_q)
                                2'd0: begin
                                    rec_w.imm16 = {8'h00, byte_c};
                                    if (imm_size_q == 2'd1) st_w = ST_HOLD;
                                end
                                2'd1: begin
                                    rec_w.imm16[15:8] = byte_c;
                                    if (imm_size_q == 2'd2) st_w = ST_HOLD;
                                end
                                default: begin
                                    rec_w.imm8b = byte_c;
                                    st_w        = ST_HOLD;
                                end
                            endcase
                        end
                        default: ;
                    endcase
                    state_d       = st_w;
                    instr_d       = rec_w;
                    instr_valid_d = (st_w == ST_HOLD);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_OPCODE;
            ipq_head_q    <= 16'h0000;
            pfp_set_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            disp_size_q   <= 2'd0;
            imm_size_q    <= 2'd0;
            imm_if_reg0_q <= 1'b0;
            byte_idx_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            ipq_head_q    <= ipq_head_d;
            pfp_set_q     <= pfp_set_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            disp_size_q   <= disp_size_d;
            imm_size_q    <= imm_size_d;
            imm_if_reg0_q <= imm_if_reg0_d;
            byte_idx_q    <= byte_idx_d;
        end
    end

    assign ipq_head    = ipq_head_q;
    assign pfp_set     = pfp_set_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a byte program in a 64 KiB memory feeds the
// IPQ window; expected records go to a scoreboard queue as the program is laid
// down and are popped when the DUT presents a valid record.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic            clk = 1'b0;
    logic            reset, ce_1, ce_2, redirect, instr_ack;
    logic [7:0][7:0] ipq;
    logic [3:0]      ipq_len;
    logic [15:0]     redirect_pc;
    logic [15:0]     ipq_head;
    logic            pfp_set, instr_valid;
    decoded_instr_t  instr;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.MAX_LEN(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce_1        (ce_1),
        .ce_2        (ce_2),
        .ipq         (ipq),
        .ipq_len     (ipq_len),
        .ipq_head    (ipq_head),
        .pfp_set     (pfp_set),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .instr       (instr)
    );

    typedef struct {
        logic [47:0]    bytes;   // first byte in [47:40]
        int             n;
        int             hold;
        decoded_instr_t exp;
    } vec_t;

    typedef struct {
        decoded_instr_t rec;
        logic [15:0]    head;
    } sb_t;

    logic [7:0] mem [0:65535];
    sb_t        sb_q[$];
    vec_t       vecs[11];
    int         n_vec = 0;
    int         n_err = 0;

    function automatic decoded_instr_t mk(logic [3:0] len, logic sv, sreg_index_e sg, rep_e rp,
                                          logic lk, logic ex, logic [7:0] op, logic [7:0] mr,
                                          logic [15:0] d, logic [15:0] im, logic [7:0] i8);
        decoded_instr_t r;
        r = '0;
        r.len = len; r.seg_valid = sv; r.seg = sg; r.rep = rp; r.buslock = lk; r.ext = ex;
        r.opcode = op; r.modrm = mr; r.disp16 = d; r.imm16 = im; r.imm8b = i8;
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One ce_1 period: ce_1 on the first clock, ce_2 on the second.
    task automatic tick();
        logic [2:0] off;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            off    = 3'(k) - ipq_head[2:0];
            ipq[k] = mem[ipq_head + 16'(off)];
        end
        ce_1 = 1'b1; ce_2 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        ce_1 = 1'b0; ce_2 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic expect_rec(string tag);
        int  t;
        sb_t s;
        t = 0;
        while (!instr_valid && t < 60) begin
            tick();
            t++;
        end
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
        end else begin
            s = sb_q.pop_front();
            chk({tag, ".valid"},     instr_valid,           1'b1);
            chk({tag, ".start_pc"},  instr.start_pc,        s.rec.start_pc);
            chk({tag, ".len"},       instr.len,             s.rec.len);
            chk({tag, ".seg"},       {instr.seg_valid, instr.seg}, {s.rec.seg_valid, s.rec.seg});
            chk({tag, ".rep"},       instr.rep,             s.rec.rep);
            chk({tag, ".lock_ext"},  {instr.buslock, instr.ext}, {s.rec.buslock, s.rec.ext});
            chk({tag, ".opcode"},    instr.opcode,          s.rec.opcode);
            chk({tag, ".modrm"},     instr.modrm,           s.rec.modrm);
            chk({tag, ".disp16"},    instr.disp16,          s.rec.disp16);
            chk({tag, ".imm16"},     instr.imm16,           s.rec.imm16);
            chk({tag, ".imm8b"},     instr.imm8b,           s.rec.imm8b);
            chk({tag, ".ipq_head"},  ipq_head,              s.head);
        end
    endtask

    initial begin
        int          pc;
        int          start;
        decoded_instr_t e;

        reset = 1'b1; ce_1 = 1'b0; ce_2 = 1'b0; redirect = 1'b0; instr_ack = 1'b0;
        ipq_len = 4'd0; redirect_pc = 16'h0000; ipq = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

        vecs[0]  = '{48'h900000000000, 1, 0, mk(1, 0, SREG_DS1, REP_NONE,  0, 0, 8'h90, 8'h00, 16'h0000, 16'h0000, 8'h00)};
        vecs[1]  = '{48'h2E8B86341200, 5, 0, mk(5, 1, SREG_PS,  REP_NONE,  0, 0, 8'h8B, 8'h86, 16'h1234, 16'h0000, 8'h00)};
        vecs[2]  = '{48'h8346FE050000, 4, 0, mk(4, 0, SREG_DS1, REP_NONE,  0, 0, 8'h83, 8'h46, 16'hFFFE, 16'h0005, 8'h00)};
        vecs[3]  = '{48'hC81000020000, 4, 5, mk(4, 0, SREG_DS1, REP_NONE,  0, 0, 8'hC8, 8'h00, 16'h0000, 16'h0010, 8'h02)};
        vecs[4]  = '{48'hF32636A50000, 4, 0, mk(4, 1, SREG_SS,  REP_REP,   0, 0, 8'hA5, 8'h00, 16'h0000, 16'h0000, 8'h00)};
        vecs[5]  = '{48'hF7D800000000, 2, 0, mk(2, 0, SREG_DS1, REP_NONE,  0, 0, 8'hF7, 8'hD8, 16'h0000, 16'h0000, 8'h00)};
        vecs[6]  = '{48'hF6C07F000000, 3, 0, mk(3, 0, SREG_DS1, REP_NONE,  0, 0, 8'hF6, 8'hC0, 16'h0000, 16'h007F, 8'h00)};
        vecs[7]  = '{48'h0F18C0050000, 4, 0, mk(4, 0, SREG_DS1, REP_NONE,  0, 1, 8'h18, 8'hC0, 16'h0000, 16'h0005, 8'h00)};
        vecs[8]  = '{48'hF0F264AC0000, 4, 0, mk(4, 0, SREG_DS1, REP_REPNC, 1, 0, 8'hAC, 8'h00, 16'h0000, 16'h0000, 8'h00)};
        vecs[9]  = '{48'h8B0600200000, 4, 0, mk(4, 0, SREG_DS1, REP_NONE,  0, 0, 8'h8B, 8'h06, 16'h2000, 16'h0000, 8'h00)};
        vecs[10] = '{48'h8A4780000000, 3, 0, mk(3, 0, SREG_DS1, REP_NONE,  0, 0, 8'h8A, 8'h47, 16'hFF80, 16'h0000, 8'h00)};

        // Lay the program down and fill the scoreboard.
        pc = 0;
        foreach (vecs[i]) begin
            for (int b = 0; b < vecs[i].n; b++)
                mem[16'(pc + b)] = vecs[i].bytes[47 - 8*b -: 8];
            e = vecs[i].exp;
            e.start_pc = 16'(pc);
            pc += vecs[i].n;
            sb_q.push_back('{e, 16'(pc)});
        end
        // 16 segment prefixes + NOP: length saturates at 15.
        start = pc;
        for (int b = 0; b < 16; b++) mem[16'(pc + b)] = 8'h2E;
        mem[16'(pc + 16)] = 8'h90;
        pc += 17;
        e = mk(15, 1, SREG_PS, REP_NONE, 0, 0, 8'h90, 8'h00, 16'h0000, 16'h0000, 8'h00);
        e.start_pc = 16'(start);
        sb_q.push_back('{e, 16'(pc)});
        // Opcode that leaves the unit waiting for a ModR/M when redirected.
        mem[16'(pc)] = 8'h8B;
        mem[16'h0100] = 8'hB0;
        mem[16'h0101] = 8'h42;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset.ipq_head", ipq_head,    16'h0000);
        chk("reset.valid",    instr_valid, 1'b0);
        chk("reset.pfp_set",  pfp_set,     1'b0);
        chk("reset.instr",    instr,       '0);

        ipq_len = 4'd8;
        for (int i = 0; i <= 11; i++) begin
            expect_rec($sformatf("v%0d", i));
            if (i < 11 && vecs[i].hold > 0) begin
                repeat (vecs[i].hold) tick();
                chk("hold.valid",    instr_valid, 1'b1);
                chk("hold.ipq_head", ipq_head,    16'(start - 0) - 16'(start) + sb_head_of(i));
                chk("hold.record",   instr,       rec_of(i));
            end
            instr_ack = 1'b1;
            tick();
            instr_ack = 1'b0;
        end

        // Redirect while waiting for ModR/M, with a stale ipq_len.
        ipq_len = 4'd3; redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        chk("redir.pfp_set",  pfp_set,     1'b1);
        chk("redir.ipq_head", ipq_head,    16'h0100);
        chk("redir.valid",    instr_valid, 1'b0);
        tick();
        chk("redir2.pfp_set",  pfp_set,  1'b0);
        chk("redir2.ipq_head", ipq_head, 16'h0100);
        e = mk(2, 0, SREG_DS1, REP_NONE, 0, 0, 8'hB0, 8'h00, 16'h0000, 16'h0042, 8'h00);
        e.start_pc = 16'h0100;
        sb_q.push_back('{e, 16'h0102});
        ipq_len = 4'd8;
        expect_rec("redir_tgt");

        // Redirect beats a simultaneous ack; then a stalled immediate across the wrap.
        mem[16'hFFFE] = 8'hB8; mem[16'hFFFF] = 8'hEF; mem[16'h0000] = 8'hBE;
        ipq_len = 4'd3; redirect = 1'b1; instr_ack = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0; instr_ack = 1'b0;
        chk("prio.pfp_set",  pfp_set,     1'b1);
        chk("prio.ipq_head", ipq_head,    16'hFFFE);
        chk("prio.valid",    instr_valid, 1'b0);
        ipq_len = 4'd1;
        tick();
        chk("prio2.ipq_head", ipq_head, 16'hFFFE);
        tick();
        chk("wrap.op_head", ipq_head, 16'hFFFF);
        ipq_len = 4'd0;
        repeat (3) tick();
        chk("stall.ipq_head", ipq_head,    16'hFFFF);
        chk("stall.valid",    instr_valid, 1'b0);
        e = mk(3, 0, SREG_DS1, REP_NONE, 0, 0, 8'hB8, 8'h00, 16'h0000, 16'hBEEF, 8'h00);
        e.start_pc = 16'hFFFE;
        sb_q.push_back('{e, 16'h0001});
        ipq_len = 4'd2;
        expect_rec("wrap");

        // Reset in the middle of a prefix sequence discards it.
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst2.ipq_head", ipq_head,    16'h0000);
        chk("rst2.valid",    instr_valid, 1'b0);
        chk("rst2.instr",    instr,       '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Expected head and record of table vector i, derived from the table itself.
    function automatic logic [15:0] sb_head_of(int i);
        int p;
        p = 0;
        for (int k = 0; k <= i; k++) p += vecs[k].n;
        return 16'(p);
    endfunction

    function automatic decoded_instr_t rec_of(int i);
        decoded_instr_t r;
        r = vecs[i].exp;
        r.start_pc = sb_head_of(i) - 16'(vecs[i].n);
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Downstream consumer of the bus control unit's instruction prefetch queue (IPQ).
- Owns the program-counter offset `ipq_head` and pulls bytes out of the 8-byte IPQ one at a time.
- Assembles one complete V33 instruction record per instruction: prefixes, opcode (including 0x0F two-byte forms), ModR/M, displacement and immediates.
- Hands the record to the execution unit over a level valid/ack handshake. Executes a flush/redirect by driving `pfp_set`.

Parameters:
- MAX_LEN, 15, instruction length saturation limit in bytes (prefixes included).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_1  in  1  phase-1 clock enable
- ce_2  in  1  phase-2 clock enable
- ipq  in  8x8  prefetch queue bytes, indexed by `ipq_head[2:0]`
- ipq_len  in  4  bytes available from the bus control unit
- ipq_head  out  16  PS offset of the next byte to consume
- pfp_set  out  1  reloads the prefetch pointer from `ipq_head`
- redirect  in  1  flush request from the execution unit
- redirect_pc  in  16  new PS offset for a redirect
- instr_valid  out  1  decoded record is valid
- instr_ack  in  1  execution unit accepted the record
- instr  out  decoded_instr_t  decoded record: start_pc, len, seg_override (valid + sreg_index_e), rep (none/REP/REPNE/REPC/REPNC), buslock, ext (0x0F form), opcode, modrm, disp16, imm16, imm8b

Behaviour:
- Reset values:
  - `ipq_head` = 0, `pfp_set` = 0, `instr_valid` = 0, `instr` all zeros, state = OPCODE.
  - Reset mid-instruction discards all partial state.
- Byte consumption:
  - All state advances on ce_1 only. `redirect` and `instr_ack` are sampled on ce_1.
  - At most one byte is consumed per ce_1, and only when `ipq_len != 0`.
  - Consuming a byte reads `ipq[ipq_head[2:0]]` and sets `ipq_head <= ipq_head + 1`. The 16-bit offset wraps 0xFFFF -> 0x0000.
- States:
  - OPCODE:
    - A prefix byte (26/2E/36/3E/F0/F2/F3/64/65) records its attribute, increments `len` and stays in OPCODE.
    - Segment overrides map 26 -> DS1, 2E -> PS, 36 -> SS, 3E -> DS0. When several segment prefixes appear, the last one wins; the same rule applies to rep prefixes.
    - Byte 0x0F sets `ext` and goes to OPCODE2.
    - Any other byte latches `opcode`, then branches on the attribute table: has_modrm -> MODRM; else imm_size > 0 -> IMM; else -> HOLD.
    - `start_pc` is latched on the first byte of an instruction (prefix or opcode).
  - OPCODE2: latches the second byte as `opcode` and branches using the extended attribute table.
  - MODRM:
    - Latches `modrm`, then sets disp_size:
      - 2 if mod=00 and rm=110
      - 1 if mod=01
      - 2 if mod=10
      - 0 otherwise
    - Goes to DISP if disp_size > 0, else to IMM or HOLD.
    - An attribute flag `imm_if_reg0` (F6/F7) suppresses the immediate unless modrm[5:3] = 000.
  - DISP:
    - Bytes fill `disp16` low byte first.
    - A 1-byte displacement is sign-extended to 16 bits.
  - IMM:
    - imm_size 1: one byte, zero-extended in `imm16`.
    - imm_size 2: `imm16` low byte first.
    - imm_size 3 (PREPARE/ENTER): `imm16` then `imm8b`.
  - HOLD:
    - `instr_valid` = 1 and `instr` is stable.
    - On ce_1 with `instr_ack`: `instr_valid` <= 0, and decode of the next instruction starts on the same ce_1. OPCODE logic runs on that byte if `ipq_len != 0`.
- Length: `len` counts every consumed byte of the instruction and saturates at MAX_LEN.
- Redirect (highest priority, any state):
  - On ce_1 with `redirect`: `ipq_head <= redirect_pc`, `pfp_set` = 1 for exactly one ce_1 period (cleared on the next ce_1), `instr_valid` <= 0, state <= OPCODE.
  - No byte is consumed in the redirect ce_1 or in the following ce_1. This is required because `ipq_len` is stale until the bus control unit has reloaded its pointer.
  - A redirect takes priority over a simultaneous `instr_ack`.
- Empty queue: the unit stalls in its current state and holds all registers.

Decomposition:
- Shared types package:
  - `decoded_instr_t` struct.
  - `rep_e` enum.
  - `opcode_attr_t` struct: has_modrm, imm_size[1:0], imm_if_reg0, is_prefix.
  - Prefix byte constants.
- Sub-module `opcode_attr_rom`: combinational; inputs (ext, byte), output `opcode_attr_t`. Holds the 256-entry primary table and the 0x0F extended table.

Test Plan:
- Reset, then IPQ streams `90` (NOP) -> `instr_valid` after 1 consumed byte; len = 1, opcode = 0x90; `ipq_head` = 1.
- Stream `2E 8B 86 34 12` -> seg_override = PS, opcode = 0x8B, modrm = 0x86, disp16 = 0x1234, len = 5.
- Stream `83 46 FE 05` -> disp16 = 0xFFFE (sign-extended), imm16 = 0x0005, len = 4.
- Stream `C8 10 00 02` (PREPARE) -> imm16 = 0x0010, imm8b = 0x02, len = 4. Then `instr_ack` held low for 5 ce_1 -> record stable, `ipq_head` unchanged.
- `redirect` with `redirect_pc` = 0x0100 mid-MODRM -> `pfp_set` high one ce_1, `ipq_head` = 0x0100, `instr_valid` = 0, and no byte consumed for 2 ce_1 even with `ipq_len` stale at 3.
- `ipq_len` = 0 during the immediate of `B8 xx xx` -> stalls in IMM; completes with imm16 = 0xBEEF once bytes `EF BE` arrive. `ipq_head` wraps correctly when starting at 0xFFFE.
